// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types and width defaults for the hazard scoreboard
package core_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_X    = 2'd1,
        FWD_M    = 2'd2,
        FWD_W    = 2'd3
    } fwd_sel_e;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

endpackage

// File: rtl/core_sb_cnt.sv
// rtl/core_sb_cnt.sv - per-register outstanding-write counters with flush clear and range checks
module core_sb_cnt #(
    parameter  int NREGS   = 32,
    parameter  int MAXPEND = 7,
    localparam int RW      = $clog2(NREGS),
    localparam int CW      = $clog2(MAXPEND + 1)
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_flush,
    input  logic                       i_issue,
    input  logic [RW-1:0]              i_issue_rd,
    input  logic                       i_retire,
    input  logic [RW-1:0]              i_retire_rd,
    output logic [NREGS-1:0][CW-1:0]   o_cnt
);

    localparam logic [CW-1:0] CMAX = CW'(MAXPEND);

    logic [NREGS-1:1][CW-1:0] r_cnt;
    logic [NREGS-1:1]         w_inc;
    logic [NREGS-1:1]         w_dec;

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int i = 1; i < NREGS; i++) begin
            w_inc[i] = i_issue  && (i_issue_rd  == RW'(i));
            w_dec[i] = i_retire && (i_retire_rd == RW'(i));
        end
    end

    // Issue and retire to the same register in one cycle cancel out.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_flush) begin
            r_cnt <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (w_inc[i] && !w_dec[i] && (r_cnt[i] != CMAX))
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != '0))
                    r_cnt[i] <= r_cnt[i] - CW'(1);
            end
        end
    end

    always @(posedge i_clk) begin
        if (i_rst_n && !i_flush) begin
            for (int i = 1; i < NREGS; i++) begin
                assert (!(w_inc[i] && !w_dec[i] && (r_cnt[i] == CMAX)));
                assert (!(w_dec[i] && !w_inc[i] && (r_cnt[i] == '0)));
            end
        end
    end

    assign o_cnt = {r_cnt, CW'(0)};

endmodule

// File: rtl/core_hazard_sb.sv
// rtl/core_hazard_sb.sv - decode hazard scoreboard; operand forwarding enabled by CORE_HAZARD_FWD_EN
module core_hazard_sb
    import core_pkg::*;
#(
    parameter  int XLEN    = XLEN_DEF,
    parameter  int NREGS   = NREGS_DEF,
    parameter  int MAXPEND = 7,
    localparam int RW      = $clog2(NREGS),
    localparam int CW      = $clog2(MAXPEND + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            d_valid,
    input  logic [RW-1:0]   d_rs1,
    input  logic [RW-1:0]   d_rs2,
    input  logic            iss_wen,
    input  logic [RW-1:0]   d_rd,
    input  logic            x_valid,
    input  logic            x_wen,
    input  logic            x_rdy,
    input  logic [RW-1:0]   x_rd,
    input  logic [XLEN-1:0] x_data,
    input  logic            m_valid,
    input  logic            m_wen,
    input  logic            m_rdy,
    input  logic [RW-1:0]   m_rd,
    input  logic [XLEN-1:0] m_data,
    input  logic            w_valid,
    input  logic            w_wen,
    input  logic [RW-1:0]   w_rd,
    input  logic [XLEN-1:0] w_data,
    input  logic            flush,
    output logic            stall,
    output fwd_sel_e        fwd1_sel,
    output fwd_sel_e        fwd2_sel,
    output logic [XLEN-1:0] fwd1_data,
    output logic [XLEN-1:0] fwd2_data
);

    logic [NREGS-1:0][CW-1:0] w_cnt;
    logic [RW-1:0]            w_rs [2];
    fwd_sel_e                 w_sel [2];
    logic [XLEN-1:0]          w_fwd [2];
    logic [1:0]               w_src_stall;
    logic                     w_issue;
    logic                     w_retire;

    assign w_rs[0]  = d_rs1;
    assign w_rs[1]  = d_rs2;
    assign w_retire = w_valid && w_wen && (w_rd != '0);
    assign stall    = d_valid && !flush && (|w_src_stall);
    assign w_issue  = d_valid && !stall && !flush && iss_wen && (d_rd != '0);

`ifdef CORE_HAZARD_FWD_EN
    // Stage priority X > M > W picks the youngest in-pipe writer of each source.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            w_sel[s]       = FWD_NONE;
            w_fwd[s]       = '0;
            w_src_stall[s] = 1'b0;
            if (w_rs[s] != '0) begin
                if (x_valid && x_wen && (x_rd == w_rs[s])) begin
                    if (x_rdy) begin
                        w_sel[s] = FWD_X;
                        w_fwd[s] = x_data;
                    end else begin
                        w_src_stall[s] = 1'b1;
                    end
                end else if (m_valid && m_wen && (m_rd == w_rs[s])) begin
                    if (m_rdy) begin
                        w_sel[s] = FWD_M;
                        w_fwd[s] = m_data;
                    end else begin
                        w_src_stall[s] = 1'b1;
                    end
                end else if (w_valid && w_wen && (w_rd == w_rs[s])) begin
                    w_sel[s] = FWD_W;
                    w_fwd[s] = w_data;
                end else begin
                    w_src_stall[s] = (w_cnt[w_rs[s]] != '0);
                end
            end
        end
    end
`else
    // Without forwarding only a same-cycle retire lets a pending source through.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            w_sel[s]       = FWD_NONE;
            w_fwd[s]       = '0;
            w_src_stall[s] = (w_cnt[w_rs[s]] != '0) && !(w_retire && (w_rd == w_rs[s]));
        end
    end

    logic w_unused_fwd;
    assign w_unused_fwd = ^{x_valid, x_wen, x_rdy, x_rd, x_data,
                            m_valid, m_wen, m_rdy, m_rd, m_data, w_data};
`endif

    assign fwd1_sel  = w_sel[0];
    assign fwd2_sel  = w_sel[1];
    assign fwd1_data = w_fwd[0];
    assign fwd2_data = w_fwd[1];

    core_sb_cnt #(
        .NREGS   (NREGS),
        .MAXPEND (MAXPEND)
    ) u_cnt (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_flush     (flush),
        .i_issue     (w_issue),
        .i_issue_rd  (d_rd),
        .i_retire    (w_retire),
        .i_retire_rd (w_rd),
        .o_cnt       (w_cnt)
    );

endmodule

// File: tb/tb_core_hazard_sb.sv
// tb/tb_core_hazard_sb.sv - self-checking bench for core_hazard_sb against a scoreboard model
module tb_core_hazard_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        d_valid, iss_wen, flush;
    logic [4:0]  d_rs1, d_rs2, d_rd;
    logic        x_valid, x_wen, x_rdy;
    logic [4:0]  x_rd;
    logic [31:0] x_data;
    logic        m_valid, m_wen, m_rdy;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic        w_valid, w_wen;
    logic [4:0]  w_rd;
    logic [31:0] w_data;
    logic        stall;
    logic [1:0]  fwd1_sel, fwd2_sel;
    logic [31:0] fwd1_data, fwd2_data;

    int n_checks = 0;
    int n_errors = 0;
    int mcnt [32];
    logic m_stall;

    always #5 clk = ~clk;

    core_hazard_sb dut (
        .clk(clk), .rst_n(rst_n),
        .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2), .iss_wen(iss_wen), .d_rd(d_rd),
        .x_valid(x_valid), .x_wen(x_wen), .x_rdy(x_rdy), .x_rd(x_rd), .x_data(x_data),
        .m_valid(m_valid), .m_wen(m_wen), .m_rdy(m_rdy), .m_rd(m_rd), .m_data(m_data),
        .w_valid(w_valid), .w_wen(w_wen), .w_rd(w_rd), .w_data(w_data),
        .flush(flush), .stall(stall),
        .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel),
        .fwd1_data(fwd1_data), .fwd2_data(fwd2_data)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_src(input logic [4:0] rs, output logic [1:0] sel,
                                      output logic [31:0] data, output logic st);
        sel  = 2'd0;
        data = 32'd0;
        st   = 1'b0;
        if (rs != 5'd0) begin
`ifdef CORE_HAZARD_FWD_EN
            if (x_valid && x_wen && x_rd == rs) begin
                if (x_rdy) begin sel = 2'd1; data = x_data; end
                else st = 1'b1;
            end else if (m_valid && m_wen && m_rd == rs) begin
                if (m_rdy) begin sel = 2'd2; data = m_data; end
                else st = 1'b1;
            end else if (w_valid && w_wen && w_rd == rs) begin
                sel = 2'd3; data = w_data;
            end else begin
                st = (mcnt[rs] > 0);
            end
`else
            st = (mcnt[rs] > 0) && !(w_valid && w_wen && w_rd == rs);
`endif
        end
    endfunction

    task automatic idle();
        d_valid = 0; iss_wen = 0; flush = 0; d_rs1 = 0; d_rs2 = 0; d_rd = 0;
        x_valid = 0; x_wen = 0; x_rdy = 0; x_rd = 0; x_data = 0;
        m_valid = 0; m_wen = 0; m_rdy = 0; m_rd = 0; m_data = 0;
        w_valid = 0; w_wen = 0; w_rd = 0; w_data = 0;
    endtask

    task automatic chk_counts();
        for (int r = 1; r < 32; r++)
            check($sformatf("cnt[%0d]", r), 64'(dut.w_cnt[r]), 64'(mcnt[r]));
    endtask

    task automatic eval();
        logic [1:0]  s1, s2;
        logic [31:0] d1, d2;
        logic        t1, t2;
        #1;
        model_src(d_rs1, s1, d1, t1);
        model_src(d_rs2, s2, d2, t2);
        m_stall = d_valid && !flush && (t1 || t2);
        check("stall", 64'(stall), 64'(m_stall));
        check("fwd1_sel", 64'(fwd1_sel), 64'(s1));
        check("fwd1_data", 64'(fwd1_data), 64'(d1));
        check("fwd2_sel", 64'(fwd2_sel), 64'(s2));
        check("fwd2_data", 64'(fwd2_data), 64'(d2));
    endtask

    task automatic adv();
        logic iss, ret, clr;
        iss = d_valid && !m_stall && !flush && iss_wen && (d_rd != 0);
        ret = w_valid && w_wen && (w_rd != 0);
        clr = flush || !rst_n;
        @(posedge clk);
        #1;
        if (clr) begin
            for (int r = 0; r < 32; r++) mcnt[r] = 0;
        end else begin
            if (iss) mcnt[d_rd] = mcnt[d_rd] + 1;
            if (ret) mcnt[w_rd] = mcnt[w_rd] - 1;
        end
        chk_counts();
    endtask

    task automatic rand_cycle();
        d_valid = ($urandom_range(0, 3) != 0);
        d_rs1   = 5'($urandom_range(0, 7));
        d_rs2   = 5'($urandom_range(0, 7));
        d_rd    = 5'($urandom_range(0, 7));
        iss_wen = 1'($urandom);
        x_valid = 1'($urandom); x_wen = 1'($urandom); x_rdy = 1'($urandom);
        x_rd    = 5'($urandom_range(0, 7)); x_data = $urandom;
        m_valid = 1'($urandom); m_wen = 1'($urandom); m_rdy = 1'($urandom);
        m_rd    = 5'($urandom_range(0, 7)); m_data = $urandom;
        w_valid = 1'($urandom); w_wen = 1'($urandom);
        w_rd    = 5'($urandom_range(0, 7)); w_data = $urandom;
        flush   = ($urandom_range(0, 19) == 0);
        if (w_valid && w_wen && mcnt[w_rd] == 0) w_wen = 0;
        if (mcnt[d_rd] >= 6) iss_wen = 0;
        eval();
        adv();
    endtask

    initial begin
        for (int r = 0; r < 32; r++) mcnt[r] = 0;
        idle();
        rst_n = 0;
        @(posedge clk);
        #1;
        d_valid = 1; d_rs1 = 3; d_rs2 = 5;
        eval();
        chk_counts();
        @(posedge clk);
        #1;
        rst_n = 1;

        // three writes to x5 then three retires
        idle(); d_valid = 1; iss_wen = 1; d_rd = 5;
        repeat (3) begin eval(); adv(); end
        check("x5_cnt_3", 64'(dut.w_cnt[5]), 64'd3);
        idle(); w_valid = 1; w_wen = 1; w_rd = 5;
        repeat (3) begin eval(); adv(); end
        check("x5_cnt_0", 64'(dut.w_cnt[5]), 64'd0);

        // x0 sources never stall or forward
        idle(); d_valid = 1; x_valid = 1; x_wen = 1; x_rd = 0; x_rdy = 1; x_data = 32'hDEAD;
        eval();
        check("x0_stall", 64'(stall), 64'd0);
        check("x0_sel1", 64'(fwd1_sel), 64'd0);
        check("x0_sel2", 64'(fwd2_sel), 64'd0);
        check("x0_data1", 64'(fwd1_data), 64'd0);
        check("x0_data2", 64'(fwd2_data), 64'd0);
        adv();

        // two writes to x7 in flight in X and M
        idle(); d_valid = 1; iss_wen = 1; d_rd = 7;
        repeat (2) begin eval(); adv(); end
        idle(); d_valid = 1; d_rs1 = 7;
        x_valid = 1; x_wen = 1; x_rd = 7; x_rdy = 1; x_data = 32'hA5;
        m_valid = 1; m_wen = 1; m_rd = 7; m_rdy = 1; m_data = 32'h11;
        eval();
`ifdef CORE_HAZARD_FWD_EN
        check("x7_sel1", 64'(fwd1_sel), 64'd1);
        check("x7_data1", 64'(fwd1_data), 64'hA5);
        check("x7_stall", 64'(stall), 64'd0);
`else
        check("x7_stall", 64'(stall), 64'd1);
`endif
        adv();

        // load to x9 waiting in M
        idle(); d_valid = 1; iss_wen = 1; d_rd = 9;
        eval(); adv();
        idle(); d_valid = 1; d_rs2 = 9; m_valid = 1; m_wen = 1; m_rd = 9; m_rdy = 0;
        repeat (2) begin eval(); check("ld_stall", 64'(stall), 64'd1); adv(); end
        m_rdy = 1; m_data = 32'h77;
        eval();
`ifdef CORE_HAZARD_FWD_EN
        check("ld_sel2", 64'(fwd2_sel), 64'd2);
        check("ld_data2", 64'(fwd2_data), 64'h77);
        check("ld_stall_rdy", 64'(stall), 64'd0);
`else
        check("ld_stall_rdy", 64'(stall), 64'd1);
`endif
        adv();

        // long-latency divide to x12
        idle(); d_valid = 1; iss_wen = 1; d_rd = 12;
        eval(); adv();
        idle(); d_valid = 1; d_rs1 = 12;
        repeat (3) begin eval(); check("div_stall", 64'(stall), 64'd1); adv(); end
        w_valid = 1; w_wen = 1; w_rd = 12; w_data = 32'h3C;
        eval();
        check("div_ret_stall", 64'(stall), 64'd0);
`ifdef CORE_HAZARD_FWD_EN
        check("div_sel1", 64'(fwd1_sel), 64'd3);
        check("div_data1", 64'(fwd1_data), 64'h3C);
`endif
        adv();

        // flush wins over a same-cycle issue
        idle(); d_valid = 1; iss_wen = 1; d_rd = 3;
        repeat (2) begin eval(); adv(); end
        d_rd = 4;
        eval(); adv();
        check("x3_cnt_2", 64'(dut.w_cnt[3]), 64'd2);
        check("x4_cnt_1", 64'(dut.w_cnt[4]), 64'd1);
        d_rd = 3; d_rs1 = 3; flush = 1;
        eval();
        check("flush_stall", 64'(stall), 64'd0);
        adv();
        check("flush_x3", 64'(dut.w_cnt[3]), 64'd0);
        check("flush_x7", 64'(dut.w_cnt[7]), 64'd0);
        idle(); d_valid = 1; d_rs1 = 3; d_rs2 = 4;
        eval();
        check("post_flush_stall", 64'(stall), 64'd0);
        adv();

        repeat (400) rand_cycle();

        // asynchronous reset in the middle of a retire cycle
        idle(); d_valid = 1; iss_wen = 1; d_rd = 6;
        repeat (2) begin eval(); adv(); end
        idle(); w_valid = 1; w_wen = 1; w_rd = 6;
        #2;
        rst_n = 0;
        #1;
        check("async_rst_x6", 64'(dut.w_cnt[6]), 64'd0);
        for (int r = 0; r < 32; r++) mcnt[r] = 0;
        idle();
        @(posedge clk);
        #1;
        chk_counts();
        rst_n = 1;
        d_valid = 1; d_rs1 = 6;
        eval();
        check("rst_no_stall", 64'(stall), 64'd0);
        adv();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/core_hazard_sb.md
CORE_HAZARD_SB -- requirements
Module: core_hazard_sb

Interface
REQ-001 The parameter XLEN, default 32, SHALL set the data width of every forwarding path.
REQ-002 The parameter NREGS, default 32, SHALL set the architectural register count; RW = $clog2(NREGS).
REQ-003 The parameter MAXPEND, default 7, SHALL set the maximum outstanding writes per register; CW = $clog2(MAXPEND+1).
REQ-004 The design SHALL use one clock and an asynchronous, active-low reset.
REQ-005 The port list SHALL be:
- clk in 1: rising-edge clock.
- rst_n in 1: asynchronous active-low reset.
- d_valid in 1: decode holds an instruction.
- d_rs1, d_rs2 in RW: decode source registers.
- iss_wen in 1: decode instruction writes d_rd.
- d_rd in RW: decode destination register.
- x_valid, x_wen, x_rdy in 1: execute stage valid, write enable, and result ready.
- x_rd in RW: execute destination register.
- x_data in XLEN: execute result.
- m_valid, m_wen, m_rdy, m_rd, m_data: memory stage, same meaning as x_*.
- w_valid, w_wen, w_rd, w_data: writeback stage; always ready.
- flush in 1: kills all instructions younger than W, including the long-latency unit.
- stall out 1: hold decode.
- fwd1_sel, fwd2_sel out 2: forwarding source, core_pkg::fwd_sel_e (NONE=0, X=1, M=2, W=3).
- fwd1_data, fwd2_data out XLEN: forwarded operand.

Function
REQ-006 The block SHALL keep one CW-bit pending counter per register, with register 0 hard-wired to zero.
REQ-007 The counter of d_rd SHALL increment on issue, where issue = d_valid & ~stall & ~flush & iss_wen & (d_rd != 0).
REQ-008 The counter of w_rd SHALL decrement on retire, where retire = w_valid & w_wen & (w_rd != 0).
REQ-009 When issue and retire hit the same register in one cycle, that counter SHALL remain unchanged.
REQ-010 When flush = 1, every counter SHALL be zero in the next cycle, regardless of same-cycle issue or retire.
REQ-011 A counter SHALL never underflow or overflow; an assertion SHALL fire on decrement at 0 or increment at MAXPEND.
REQ-012 For each source rsN != 0, the producer SHALL be the youngest stage among X, M, W with valid & wen & rd == rsN.
REQ-013 If the producer is X or M with rdy = 1, fwdN_sel SHALL equal that stage and fwdN_data SHALL equal its data.
REQ-014 If the producer is W, fwdN_sel SHALL be W and fwdN_data SHALL be w_data.
REQ-015 Source rsN SHALL raise stall when the producer is X or M with rdy = 0.
REQ-016 Source rsN SHALL raise stall when it has no producer but its counter is nonzero, meaning the result is held in the long-latency unit.
REQ-017 A counter value of 1 whose only producer is the W stage SHALL NOT stall.
REQ-018 stall SHALL be forced to 0 when d_valid = 0 or flush = 1.
REQ-019 fwdN_sel SHALL be NONE and fwdN_data SHALL be 0 whenever rsN = 0 or no forwarding applies.
REQ-020 All outputs SHALL be combinational from inputs and counter state, with zero-cycle latency.
REQ-021 A stalled decode SHALL NOT increment any counter.

Reset
REQ-022 While rst_n = 0, all counters SHALL be 0 asynchronously.
REQ-023 While rst_n = 0, stall SHALL be 0 when d_valid = 0, and the outputs SHALL follow REQ-012..019 with zeroed counters.
REQ-024 Reset asserted mid-operation SHALL discard all pending state, with no partial decrement.

Configuration
REQ-025 With CORE_HAZARD_FWD_EN defined, forwarding SHALL behave as specified in REQ-012..019.
REQ-026 Without CORE_HAZARD_FWD_EN, fwdN_sel SHALL be tied to NONE and fwdN_data to 0.
REQ-027 Without CORE_HAZARD_FWD_EN, stall SHALL assert for every source whose counter is nonzero, except when retire of that register occurs in the same cycle.

Structure
REQ-028 The package core_pkg SHALL hold fwd_sel_e, XLEN, and NREGS defaults.
REQ-029 The per-register counter array SHALL be the sub-module core_sb_cnt, covering increment, decrement, flush clear, and the assertions.
REQ-030 The RTL SHALL be 120-400 lines in total.

Verification
REQ-031 Issue 3 writes to x5 with no retire, then check x5 count = 3, then 3 retires -> count = 0, with no assertion firing.
REQ-032 Set x_valid = 1, x_wen = 1, x_rd = 7, x_rdy = 1, x_data = 0xA5, and m_rd = 7 with m_data = 0x11; set d_rs1 = 7 -> fwd1_sel = X, fwd1_data = 0xA5, stall = 0.
REQ-033 Set m_rd = 9 with m_rdy = 0 (load) and d_rs2 = 9 -> stall = 1 until m_rdy = 1, then fwd2_sel = M with no stall.
REQ-034 Issue a divide to x12, leaving X/M/W empty, and set d_rs1 = 12 -> stall = 1 until W retires x12 with w_data = 0x3C, which gives fwd1_sel = W and fwd1_data = 0x3C.
REQ-035 Hold counts x3 = 2 and x4 = 1, then assert flush with a simultaneous issue to x3 -> all counts = 0 next cycle and stall = 0.
REQ-036 Set d_rs1 = d_rs2 = 0 with x_rd = 0 and x_wen = 1 -> stall = 0, both sel = NONE, both data = 0; repeat with CORE_HAZARD_FWD_EN undefined for REQ-032 -> stall = 1.
